// File: rtl/instr_encoder.sv
// RV32I field-set to instruction-word encoder with a single output register and sequential addressing.
// Optional IMM_RANGE_CHECK_EN rejects immediates that do not fit the selected format.
module instr_encoder #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] BASE_ADDR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      f3,
  input  logic [6:0]      f7,
  input  logic [4:0]      srcRegister1,
  input  logic [4:0]      srcRegister2,
  input  logic [4:0]      desRegister,
  input  logic [XLEN-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] out_addr,
  output logic            err
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_SYS   = 7'b1110011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_JAL   = 7'b1101111;

  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_BAD} fmt_e;

  fmt_e            fmt;
  logic [31:0]     enc;
  logic            imm_ok;
  logic            legal;
  logic            in_hs, out_hs;

  logic            out_valid_d, out_valid_q;
  logic            err_d, err_q;
  logic [XLEN-1:0] instr_d, instr_q;
  logic [XLEN-1:0] addr_d, addr_q;

  always_comb begin
    fmt = FMT_BAD;
    case (opcode)
      OP_R:                             fmt = FMT_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS: fmt = FMT_I;
      OP_STORE:                         fmt = FMT_S;
      OP_BR:                            fmt = FMT_B;
      OP_LUI, OP_AUIPC:                 fmt = FMT_U;
      OP_JAL:                           fmt = FMT_J;
      default:                          fmt = FMT_BAD;
    endcase
  end

  always_comb begin
    enc = '0;
    case (fmt)
      FMT_R: enc = {f7, srcRegister2, srcRegister1, f3, desRegister, opcode};
      FMT_I: enc = {imm[11:0], srcRegister1, f3, desRegister, opcode};
      FMT_S: enc = {imm[11:5], srcRegister2, srcRegister1, f3, imm[4:0], opcode};
      FMT_B: enc = {imm[12], imm[10:5], srcRegister2, srcRegister1, f3,
                    imm[4:1], imm[11], opcode};
      FMT_U: enc = {imm[31:12], desRegister, opcode};
      FMT_J: enc = {imm[20], imm[10:1], imm[11], imm[19:12], desRegister, opcode};
      default: enc = '0;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic signed [XLEN-1:0] simm;
  assign simm = $signed(imm);

  // Branch/jump offsets must also be even; U immediates carry no low bits.
  always_comb begin
    imm_ok = 1'b1;
    case (fmt)
      FMT_I, FMT_S: imm_ok = (simm >= -2048) && (simm <= 2047);
      FMT_B:        imm_ok = (simm >= -4096) && (simm <= 4094) && !imm[0];
      FMT_J:        imm_ok = (simm >= -(1 << 20)) && (simm <= (1 << 20) - 2) && !imm[0];
      FMT_U:        imm_ok = (imm[11:0] == 12'd0);
      default:      imm_ok = 1'b1;
    endcase
  end
`else
  assign imm_ok = 1'b1;
`endif

  assign legal    = (fmt != FMT_BAD) && imm_ok;
  assign in_ready = !out_valid_q || out_ready;
  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid_q && out_ready;

  // addr_q names the slot of the word in the register, or the next slot when empty.
  always_comb begin
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    err_d       = 1'b0;
    if (out_hs) begin
      out_valid_d = 1'b0;
      addr_d      = addr_q + XLEN'(4);
    end
    if (in_hs) begin
      if (legal) begin
        out_valid_d = 1'b1;
        instr_d     = XLEN'(enc);
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      err_q       <= 1'b0;
      instr_q     <= '0;
      addr_q      <= BASE_ADDR;
    end else begin
      out_valid_q <= out_valid_d;
      err_q       <= err_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign err         = err_q;
  assign instruction = instr_q;
  assign out_addr    = addr_q;

endmodule
